ethernet_header_rx: RTL and testbench
=====================================

Name: ethernet_header_rx

Overview:
- Sits directly upstream of network_rx. Consumes the MSB-first, byte-aligned N-bit stream of one Ethernet frame (preamble/SFD already stripped, FCS still present).
- Parses the 14-byte MAC header and filters on destination MAC and ethertype.
- Forwards the payload to network_rx with a registered one-cycle delay, together with ethertype_out (0 = IPv4, 1 = ARP).
- Frames that fail the filters produce no output.

Parameters:
- N, 2, stream width in bits; must divide 8 (legal values 1, 2, 4, 8).
- MAC_ADDR, 48'h69_69_5A_06_54_91, station address accepted as destination.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- axiiv  input  1  frame valid; high for the whole frame, low between frames.
- axiid  input  N  frame data, MSB-first within each byte.
- axiov  output  1  payload valid to network_rx.
- axiod  output  N  payload data to network_rx.
- ethertype_out  output  1  0 = IPv4 (0x0800), 1 = ARP (0x0806); held between frames.
- src_mac_out  output  48  source MAC of the last accepted frame.
- frame_start  output  1  one-cycle pulse coincident with the first payload axiov.
- drop_count  output  8  saturating count of rejected frames.

Behaviour:
- Reset: while rst is 0, all outputs are 0, the FSM is in IDLE, and counters are cleared. Reset takes effect immediately, even mid-frame. A partial frame in progress at reset release is not resumed; the FSM waits for axiiv low before it will start a new frame.
- Counter: counts N-bit words. Header length is HDR = 112/N words (56 for N=2). Counter width is clog2(HDR+1).
- FSM states: IDLE, HEADER, PAYLOAD, DROP, WAIT_IDLE.
- IDLE: on axiiv=1, capture word 0 and go to HEADER.
- HEADER:
  - Shift words into a 112-bit header register.
  - At the word completing the destination MAC (word 48/N−1): if the destination is neither MAC_ADDR nor 48'hFFFF_FFFF_FFFF, go to DROP immediately.
  - At word HDR−1, decode the ethertype:
    - 0x0800: ethertype_out←0.
    - 0x0806: ethertype_out←1.
    - Any other value: go to DROP.
  - On an accepted header, load src_mac_out and go to PAYLOAD.
  - axiiv falling before HDR words have arrived (runt frame): go to IDLE, increment drop_count, leave outputs unchanged.
- PAYLOAD: axiov and axiod are registered copies of axiiv and axiid, so latency is exactly 1 cycle. The first payload word is input word HDR; it appears on axiod one cycle after it is presented. The cycle where axiiv falls returns the FSM to IDLE, and axiov goes to 0 on the following cycle.
- DROP: axiov stays 0. drop_count increments once per frame, on entry, and saturates at 255. On axiiv=0, go to IDLE.
- WAIT_IDLE: used only after reset release with axiiv=1; go to IDLE when axiiv=0.
- ethertype_out and src_mac_out change only at header acceptance. They are stable for the whole payload and after it, which keeps network_rx muxing glitch-free.
- frame_start: high exactly on the cycle axiov first rises for a frame.
- Back-to-back frames: one idle cycle (axiiv=0) between frames is sufficient. The FSM accepts axiiv=1 on the cycle right after returning to IDLE.
- The FCS is not checked and is forwarded as payload; downstream stages use IP length to ignore it.

Test Plan:
- Frame with dst=MAC_ADDR, src=12'h... 0xDEADBEEF0102, type 0x0800, payload bytes 0x45,0x00 (N=2):
  - axiov first rises 57 cycles after axiiv rises.
  - First axiod dibits are 01,00,01,01; ethertype_out=0; src_mac_out=48'hDEAD_BEEF_0102; frame_start pulses once.
- Broadcast dst FF:FF:FF:FF:FF:FF with type 0x0806 and a 28-byte ARP body:
  - ethertype_out=1 from payload start.
  - Exactly 112 axiov cycles are produced.
- dst=02:00:00:00:00:01, type 0x0800: axiov never rises, drop_count goes 0→1, src_mac_out is unchanged.
- Type 0x86DD with valid dst: no output, drop_count increments. Then a valid IPv4 frame after one idle cycle is forwarded normally.
- 10-byte runt frame: FSM back in IDLE, drop_count +1. rst pulsed low mid-payload: axiov=0 in the same cycle, with no output until the next frame.
- 260 bad frames: drop_count saturates at 255.

Source files
------------

// File: rtl/ethernet_header_rx.sv
// Ethernet MAC header receiver: parses the 14-byte header of an MSB-first N-bit stream,
// filters on destination MAC and ethertype, and forwards the payload one cycle later.
module ethernet_header_rx #(
  parameter int          N        = 2,
  parameter logic [47:0] MAC_ADDR = 48'h69_69_5A_06_54_91
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         axiiv,
  input  logic [N-1:0] axiid,
  output logic         axiov,
  output logic [N-1:0] axiod,
  output logic         ethertype_out,
  output logic [47:0]  src_mac_out,
  output logic         frame_start,
  output logic [7:0]   drop_count
);

  localparam int HDR      = 112 / N;
  localparam int DST_LAST = 48 / N - 1;
  localparam int CNT_W    = $clog2(HDR + 1);

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    DROP,
    WAIT_IDLE
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [111-N:0]    r_hdr;
  logic              r_armed;
  logic              r_first;

  logic [111:0]      w_hdrNext;
  logic [15:0]       w_etherType;
  logic              w_dstEarlyOk;
  logic              w_dstFullOk;
  logic              w_typeOk;
  logic [7:0]        w_dropNext;

  // The incoming word completes the header; the destination is visible in the low
  // 48 bits at word DST_LAST and in the top 48 bits once all HDR words are in.
  assign w_hdrNext    = {r_hdr, axiid};
  assign w_etherType  = w_hdrNext[15:0];
  assign w_dstEarlyOk = (w_hdrNext[47:0] == MAC_ADDR) || (w_hdrNext[47:0] == 48'hFFFF_FFFF_FFFF);
  assign w_dstFullOk  = (w_hdrNext[111:64] == MAC_ADDR) || (w_hdrNext[111:64] == 48'hFFFF_FFFF_FFFF);
  assign w_typeOk     = (w_etherType == 16'h0800) || (w_etherType == 16'h0806);
  assign w_dropNext   = (drop_count == 8'hFF) ? 8'hFF : drop_count + 8'd1;

  // r_armed stays low after reset until axiiv has been seen low, so a frame cut by reset is never resumed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_hdr         <= '0;
      r_armed       <= 1'b0;
      r_first       <= 1'b0;
      axiov         <= 1'b0;
      axiod         <= '0;
      ethertype_out <= 1'b0;
      src_mac_out   <= '0;
      frame_start   <= 1'b0;
      drop_count    <= '0;
    end else begin
      axiov       <= 1'b0;
      axiod       <= '0;
      frame_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (axiiv) begin
            if (r_armed) begin
              r_hdr   <= w_hdrNext[111-N:0];
              r_cnt   <= CNT_W'(1);
              r_state <= HEADER;
            end else begin
              r_state <= WAIT_IDLE;
            end
          end else begin
            r_armed <= 1'b1;
          end
        end

        HEADER: begin
          if (!axiiv) begin
            drop_count <= w_dropNext;
            r_state    <= IDLE;
          end else begin
            r_hdr <= w_hdrNext[111-N:0];
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(DST_LAST) && !w_dstEarlyOk) begin
              drop_count <= w_dropNext;
              r_state    <= DROP;
            end else if (r_cnt == CNT_W'(HDR - 1)) begin
              if (w_typeOk && w_dstFullOk) begin
                ethertype_out <= (w_etherType == 16'h0806);
                src_mac_out   <= w_hdrNext[63:16];
                r_first       <= 1'b1;
                r_state       <= PAYLOAD;
              end else begin
                drop_count <= w_dropNext;
                r_state    <= DROP;
              end
            end
          end
        end

        PAYLOAD: begin
          axiov <= axiiv;
          if (axiiv) begin
            axiod       <= axiid;
            frame_start <= r_first;
            r_first     <= 1'b0;
          end else begin
            r_first <= 1'b0;
            r_state <= IDLE;
          end
        end

        DROP: begin
          if (!axiiv) r_state <= IDLE;
        end

        WAIT_IDLE: begin
          if (!axiiv) begin
            r_armed <= 1'b1;
            r_state <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ethernet_header_rx.sv
// Directed testbench for ethernet_header_rx (N=2): frames are hand-built byte lists,
// and every expected value is written out by hand.
module tb_ethernet_header_rx;

  localparam int          N   = 2;
  localparam logic [47:0] MAC = 48'h69_69_5A_06_54_91;

  logic         clk = 1'b0;
  logic         rst;
  logic         axiiv;
  logic [N-1:0] axiid;
  logic         axiov;
  logic [N-1:0] axiod;
  logic         ethertype_out;
  logic [47:0]  src_mac_out;
  logic         frame_start;
  logic [7:0]   drop_count;

  int testsRun    = 0;
  int testsFailed = 0;

  int          cycleIdx;
  int          rxCount;
  int          firstRise;
  int          fsCount;
  int          fsBad;
  logic        ethAtStart;
  logic [1:0]  rxData[$];
  logic [7:0]  frame[$];

  ethernet_header_rx #(.N(N), .MAC_ADDR(MAC)) dut (
    .clk          (clk),
    .rst          (rst),
    .axiiv        (axiiv),
    .axiid        (axiid),
    .axiov        (axiov),
    .axiod        (axiod),
    .ethertype_out(ethertype_out),
    .src_mac_out  (src_mac_out),
    .frame_start  (frame_start),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic clearRx();
    cycleIdx   = 0;
    rxCount    = 0;
    firstRise  = -1;
    fsCount    = 0;
    fsBad      = 0;
    ethAtStart = 1'bx;
    rxData.delete();
  endtask

  // One stream word per clock; outputs are sampled 1ns after the edge that consumed it.
  task automatic driveWord(input logic v, input logic [1:0] d);
    axiiv = v;
    axiid = d;
    @(posedge clk);
    #1;
    if (axiov === 1'b1) begin
      rxCount++;
      rxData.push_back(axiod);
      if (firstRise < 0) begin
        firstRise  = cycleIdx + 1;
        ethAtStart = ethertype_out;
        if (frame_start !== 1'b1) fsBad++;
      end
    end
    if (frame_start === 1'b1) begin
      fsCount++;
      if (axiov !== 1'b1) fsBad++;
    end
    cycleIdx++;
  endtask

  task automatic driveBytes(input int fromIdx, input int toIdx);
    for (int i = fromIdx; i < toIdx; i++)
      for (int d = 3; d >= 0; d--)
        driveWord(1'b1, frame[i][2*d +: 2]);
  endtask

  // Sends the whole frame, then one idle cycle.
  task automatic applyStimulus();
    clearRx();
    driveBytes(0, frame.size());
    driveWord(1'b0, 2'b00);
  endtask

  task automatic buildHeader(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] etype);
    frame.delete();
    for (int i = 5; i >= 0; i--) frame.push_back(dst[8*i +: 8]);
    for (int i = 5; i >= 0; i--) frame.push_back(src[8*i +: 8]);
    frame.push_back(etype[15:8]);
    frame.push_back(etype[7:0]);
  endtask

  function automatic logic [7:0] rxByte(input int k);
    if (k >= 0 && rxData.size() >= 4*k + 4)
      return {rxData[4*k], rxData[4*k+1], rxData[4*k+2], rxData[4*k+3]};
    return 8'hxx;
  endfunction

  initial begin
    rst   = 1'b0;
    axiiv = 1'b0;
    axiid = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstAxiov", axiov, 0);
    checkOutput("rstAxiod", axiod, 0);
    checkOutput("rstEther", ethertype_out, 0);
    checkOutput("rstSrc", src_mac_out, 0);
    checkOutput("rstFs", frame_start, 0);
    checkOutput("rstDrop", drop_count, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Unicast IPv4 frame to the station address
    buildHeader(MAC, 48'hDEAD_BEEF_0102, 16'h0800);
    frame.push_back(8'h45);
    frame.push_back(8'h00);
    applyStimulus();
    checkOutput("ipv4Latency", firstRise, 57);
    checkOutput("ipv4Count", rxCount, 8);
    checkOutput("ipv4Byte0", rxByte(0), 8'h45);
    checkOutput("ipv4Byte1", rxByte(1), 8'h00);
    checkOutput("ipv4EthStart", ethAtStart, 0);
    checkOutput("ipv4Src", src_mac_out, 48'hDEAD_BEEF_0102);
    checkOutput("ipv4FsCount", fsCount, 1);
    checkOutput("ipv4FsAlign", fsBad, 0);
    checkOutput("ipv4Drop", drop_count, 0);

    // Broadcast ARP with a 28-byte body
    buildHeader(48'hFFFF_FFFF_FFFF, 48'h1122_3344_5566, 16'h0806);
    for (int i = 0; i < 28; i++) frame.push_back(8'hA0 + 8'(i));
    applyStimulus();
    checkOutput("arpEthStart", ethAtStart, 1);
    checkOutput("arpCount", rxCount, 112);
    checkOutput("arpFirst", rxByte(0), 8'hA0);
    checkOutput("arpLast", rxByte(27), 8'hBB);
    checkOutput("arpEthAfter", ethertype_out, 1);
    checkOutput("arpSrc", src_mac_out, 48'h1122_3344_5566);
    checkOutput("arpFsCount", fsCount, 1);
    checkOutput("arpLatency", firstRise, 57);

    // Foreign destination is dropped
    buildHeader(48'h0200_0000_0001, 48'hCAFE_CAFE_CAFE, 16'h0800);
    for (int i = 0; i < 4; i++) frame.push_back(8'h55);
    applyStimulus();
    checkOutput("badDstCount", rxCount, 0);
    checkOutput("badDstFs", fsCount, 0);
    checkOutput("badDstDrop", drop_count, 1);
    checkOutput("badDstSrc", src_mac_out, 48'h1122_3344_5566);
    checkOutput("badDstEth", ethertype_out, 1);

    // Unsupported ethertype, then a good frame after one idle cycle
    buildHeader(MAC, 48'h0A0B_0C0D_0E0F, 16'h86DD);
    for (int i = 0; i < 4; i++) frame.push_back(8'h60);
    applyStimulus();
    checkOutput("v6Count", rxCount, 0);
    checkOutput("v6Drop", drop_count, 2);
    checkOutput("v6Src", src_mac_out, 48'h1122_3344_5566);
    buildHeader(MAC, 48'hAABB_CCDD_EEFF, 16'h0800);
    frame.push_back(8'hC3);
    frame.push_back(8'h5A);
    applyStimulus();
    checkOutput("b2bCount", rxCount, 8);
    checkOutput("b2bLatency", firstRise, 57);
    checkOutput("b2bByte0", rxByte(0), 8'hC3);
    checkOutput("b2bByte1", rxByte(1), 8'h5A);
    checkOutput("b2bEth", ethAtStart, 0);
    checkOutput("b2bSrc", src_mac_out, 48'hAABB_CCDD_EEFF);
    checkOutput("b2bDrop", drop_count, 2);

    // 10-byte runt, then a good ARP frame proves the FSM is back in IDLE
    buildHeader(MAC, 48'h1111_1111_1111, 16'h0800);
    while (frame.size() > 10) void'(frame.pop_back());
    applyStimulus();
    checkOutput("runtCount", rxCount, 0);
    checkOutput("runtDrop", drop_count, 3);
    checkOutput("runtSrc", src_mac_out, 48'hAABB_CCDD_EEFF);
    buildHeader(MAC, 48'h5566_7788_99AA, 16'h0806);
    for (int i = 1; i <= 4; i++) frame.push_back(8'(i));
    applyStimulus();
    checkOutput("postRuntCount", rxCount, 16);
    checkOutput("postRuntEth", ethAtStart, 1);
    checkOutput("postRuntByte0", rxByte(0), 8'h01);
    checkOutput("postRuntSrc", src_mac_out, 48'h5566_7788_99AA);

    // Reset mid-payload: outputs clear at once and the rest of the frame is ignored
    buildHeader(MAC, 48'h1234_5678_9ABC, 16'h0800);
    for (int i = 0; i < 8; i++) frame.push_back(8'hF0);
    clearRx();
    driveBytes(0, 16);
    checkOutput("preRstCount", rxCount, 8);
    checkOutput("preRstValid", axiov, 1);
    rst = 1'b0;
    #1;
    checkOutput("midRstAxiov", axiov, 0);
    checkOutput("midRstSrc", src_mac_out, 0);
    checkOutput("midRstDrop", drop_count, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    clearRx();
    driveBytes(16, frame.size());
    driveWord(1'b0, 2'b00);
    checkOutput("tailCount", rxCount, 0);
    checkOutput("tailSrc", src_mac_out, 0);
    buildHeader(MAC, 48'h0F0E_0D0C_0B0A, 16'h0800);
    frame.push_back(8'h45);
    frame.push_back(8'h00);
    applyStimulus();
    checkOutput("postRstCount", rxCount, 8);
    checkOutput("postRstLatency", firstRise, 57);
    checkOutput("postRstSrc", src_mac_out, 48'h0F0E_0D0C_0B0A);

    // drop_count saturation with short foreign-destination frames
    for (int f = 1; f <= 260; f++) begin
      buildHeader(48'h0200_0000_0001, 48'h0, 16'h0800);
      while (frame.size() > 6) void'(frame.pop_back());
      applyStimulus();
      if (f == 254) checkOutput("drop254", drop_count, 254);
      if (f == 255) checkOutput("drop255", drop_count, 255);
    end
    checkOutput("dropSat", drop_count, 255);
    checkOutput("satCount", rxCount, 0);
    checkOutput("satSrc", src_mac_out, 48'h0F0E_0D0C_0B0A);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
